mem_load_driver: RTL and testbench

MEM_LOAD_DRIVER -- requirements
Module: mem_load_driver

---
 rtl/mem_load_driver.sv | 140 ++++++++++++++
 tb/tb_mem_load_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_driver.sv
// Host-to-core tile loader: accepts words over a valid/ready handshake and turns them into registered memory write strobes.
// Optional running checksum of loaded words is built only when LOAD_CHECKSUM_EN is defined.
module mem_load_driver #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [IO_DATA_WIDTH-1:0] in_addr,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic [1:0]               in_kind,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [IO_DATA_WIDTH-1:0] a_input,
  output logic [IO_DATA_WIDTH-1:0] b_input,
  output logic                     int_mem_we,
  output logic                     overlap_cache_we,
  output logic                     data_ready,
  input  logic                     fsm_done,
  output logic [COUNT_WIDTH-1:0]   load_count,
  output logic                     kind_err,
  output logic [IO_DATA_WIDTH-1:0] load_checksum,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     in_ready_q;
  logic                     data_ready_q;
  logic [IO_DATA_WIDTH-1:0] a_q, b_q;
  logic [IO_DATA_WIDTH-1:0] addr_map;
  logic                     int_we_q, oc_we_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     kind_err_q;
  logic                     accept;
  logic                     done_exit;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready is only ever high while loading, so the host must
  // hold its word through FLUSH and READY.
  always_comb begin
    accept    = in_valid && in_ready_q;
    done_exit = (state_q == ST_READY) && fsm_done;
    state_d   = state_q;
    case (state_q)
      ST_LOAD:  if (accept && in_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_READY;
      ST_READY: if (fsm_done) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    addr_map = '0;
    case (in_kind)
      2'b00:   addr_map = {2'b00, in_addr[13:0]};
      2'b01:   addr_map = {1'b1, 6'b000000, in_addr[8:0]};
      2'b10:   addr_map = {8'h00, in_addr[7:0]};
      default: addr_map = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= ST_LOAD;
      in_ready_q   <= 1'b0;
      data_ready_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      int_we_q     <= 1'b0;
      oc_we_q      <= 1'b0;
      count_q      <= '0;
      kind_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == ST_LOAD);
      data_ready_q <= (state_d == ST_READY);
      int_we_q     <= 1'b0;
      oc_we_q      <= 1'b0;
      if (accept) begin
        // Reserved kind is counted but never written, so the bus holds its last write.
        case (in_kind)
          2'b00, 2'b01: begin
            a_q      <= addr_map;
            b_q      <= in_data;
            int_we_q <= 1'b1;
          end
          2'b10: begin
            a_q     <= addr_map;
            b_q     <= in_data;
            oc_we_q <= 1'b1;
          end
          default: kind_err_q <= 1'b1;
        endcase
      end
      if (done_exit)
        count_q <= '0;
      else if (accept)
        count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [IO_DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      csum_q <= '0;
    else if (done_exit)
      csum_q <= '0;
    else if (accept)
      csum_q <= csum_q + in_data;
  end

  assign load_checksum = csum_q;
`else
  assign load_checksum = '0;
`endif

  // Upper address bits are outside every target memory's range.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[IO_DATA_WIDTH-1:14];

  assign in_ready         = in_ready_q;
  assign data_ready       = data_ready_q;
  assign a_input          = a_q;
  assign b_input          = b_q;
  assign int_mem_we       = int_we_q;
  assign overlap_cache_we = oc_we_q;
  assign load_count       = count_q;
  assign kind_err         = kind_err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_load_driver.sv
// Directed bench for mem_load_driver: linear sequence of steps checked with immediate assertions.
module tb_mem_load_driver;

`ifdef LOAD_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk;
  logic        arst_n_in;
  logic [15:0] in_addr, in_data;
  logic [1:0]  in_kind;
  logic        in_last, in_valid, in_ready;
  logic [15:0] a_input, b_input;
  logic        int_mem_we, overlap_cache_we, data_ready, fsm_done;
  logic [15:0] load_count;
  logic        kind_err;
  logic [15:0] load_checksum;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  mem_load_driver #(.IO_DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .in_addr(in_addr), .in_data(in_data), .in_kind(in_kind),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .a_input(a_input), .b_input(b_input),
    .int_mem_we(int_mem_we), .overlap_cache_we(overlap_cache_we),
    .data_ready(data_ready), .fsm_done(fsm_done),
    .load_count(load_count), .kind_err(kind_err),
    .load_checksum(load_checksum), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [1:0] kind, input logic [15:0] addr,
                            input logic [15:0] data, input logic last);
    in_valid = 1'b1;
    in_kind  = kind;
    in_addr  = addr;
    in_data  = data;
    in_last  = last;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_a"}, a_input, 0);
    check({tag, "_b"}, b_input, 0);
    check({tag, "_int_we"}, int_mem_we, 0);
    check({tag, "_oc_we"}, overlap_cache_we, 0);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_count"}, load_count, 0);
    check({tag, "_kind_err"}, kind_err, 0);
    check({tag, "_csum"}, load_checksum, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    arst_n_in = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 2'b00;
    in_addr   = '0;
    in_data   = '0;
    in_last   = 1'b0;
    fsm_done  = 1'b0;
    #1;
    check_all_zero("reset");
    #1 arst_n_in = 1'b1;
    tick();
    check("ready_after_reset", in_ready, 1);

    // Kind 00 word
    drive_word(2'b00, 16'h0123, 16'h00AA, 1'b0);
    tick();
    in_valid = 1'b0;
    check("w1_a", a_input, 16'h0123);
    check("w1_b", b_input, 16'h00AA);
    check("w1_int_we", int_mem_we, 1);
    check("w1_oc_we", overlap_cache_we, 0);
    check("w1_count", load_count, 1);
    tick();
    check("w1_strobe_drop", int_mem_we, 0);
    check("w1_a_hold", a_input, 16'h0123);

    // Kind 01 then kind 10 with last
    drive_word(2'b01, 16'h01FF, 16'h0005, 1'b0);
    tick();
    check("w2_a", a_input, 16'h81FF);
    check("w2_int_we", int_mem_we, 1);
    drive_word(2'b10, 16'h0042, 16'h0007, 1'b1);
    tick();
    check("w3_a", a_input, 16'h0042);
    check("w3_b", b_input, 16'h0007);
    check("w3_oc_we", overlap_cache_we, 1);
    check("w3_int_we", int_mem_we, 0);
    check("w3_data_ready_early", data_ready, 0);
    check("w3_in_ready", in_ready, 0);
    check("w3_count", load_count, 3);
    check("w3_state_flush", dbg_state, 1);
    // Host holds its next word through FLUSH/READY
    drive_word(2'b00, 16'h0005, 16'h1111, 1'b1);
    tick();
    check("t1_data_ready", data_ready, 1);
    check("t1_state_ready", dbg_state, 2);
    check("t1_oc_we_drop", overlap_cache_we, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ready_hold_count", load_count, 3);
      check("ready_hold_in_ready", in_ready, 0);
      check("ready_hold_int_we", int_mem_we, 0);
    end
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("done_data_ready", data_ready, 0);
    check("done_in_ready", in_ready, 1);
    check("done_count", load_count, 0);
    check("done_state", dbg_state, 0);

    // Held word now transfers as a single-word tile
    tick();
    in_valid = 1'b0;
    check("sw_a", a_input, 16'h0005);
    check("sw_b", b_input, 16'h1111);
    check("sw_int_we", int_mem_we, 1);
    check("sw_count", load_count, 1);
    check("sw_state_flush", dbg_state, 1);
    check("sw_data_ready_early", data_ready, 0);
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("sw_data_ready", data_ready, 1);
    check("flush_done_ignored", dbg_state, 2);
    tick();
    check("sw_still_ready", data_ready, 1);
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("sw_exit", dbg_state, 0);

    // Reserved kind
    drive_word(2'b11, 16'h0010, 16'hBEEF, 1'b0);
    tick();
    check("k11_int_we", int_mem_we, 0);
    check("k11_oc_we", overlap_cache_we, 0);
    check("k11_kind_err", kind_err, 1);
    check("k11_count", load_count, 1);
    check("k11_a_hold", a_input, 16'h0005);
    drive_word(2'b00, 16'h4001, 16'h2222, 1'b1);
    tick();
    in_valid = 1'b0;
    check("k00_mask_a", a_input, 16'h0001);
    check("k00_mask_int_we", int_mem_we, 1);
    check("k11_count2", load_count, 2);
    tick();
    check("k11_tile_ready", data_ready, 1);
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("kind_err_sticky", kind_err, 1);

    // fsm_done in LOAD is ignored; then reset mid-tile
    drive_word(2'b00, 16'h0100, 16'h0001, 1'b0);
    tick();
    in_valid = 1'b0;
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("load_done_ignored_count", load_count, 1);
    check("load_done_ignored_state", dbg_state, 0);
    drive_word(2'b01, 16'h0002, 16'h0002, 1'b0);
    tick();
    drive_word(2'b10, 16'h0003, 16'h0003, 1'b0);
    tick();
    in_valid = 1'b0;
    check("r3_oc_we", overlap_cache_we, 1);
    check("r3_count", load_count, 3);
    #2 arst_n_in = 1'b0;
    #1;
    check_all_zero("midreset");
    #1 arst_n_in = 1'b1;
    tick();
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_state", dbg_state, 0);
    check("post_reset_count", load_count, 0);
    check("post_reset_oc_we", overlap_cache_we, 0);

    // Checksum tile
    drive_word(2'b00, 16'h0000, 16'hFFFF, 1'b0);
    tick();
    check("cs_first", load_checksum, CS_EN ? 16'hFFFF : 16'h0000);
    drive_word(2'b00, 16'h0001, 16'h0002, 1'b1);
    tick();
    in_valid = 1'b0;
    check("cs_accept", load_checksum, CS_EN ? 16'h0001 : 16'h0000);
    tick();
    check("cs_ready_dr", data_ready, 1);
    check("cs_ready", load_checksum, CS_EN ? 16'h0001 : 16'h0000);
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("cs_cleared", load_checksum, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
